rc_tri_unpacker: RTL and testbench

- Upstream neighbour of the raster core.
- Accepts 10-beat, 32-bit AXI4-Stream triangle packets in this order: header, lambda_zero[0..1], lambda_diff[0..3], z_zero, z_diff[0..1].
- Assembles each packet into one parallel triangle descriptor and presents it to the raster core with a valid/ready handshake.
- Double-buffered so a new packet can arrive while the previous descriptor waits. Malformed packets are dropped and flagged.

---
 rtl/rc_tri_unpacker_if.sv | 33 +++
 rtl/rc_tri_unpacker.sv | 147 ++++++++++++++
 tb/tb_rc_tri_unpacker.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rc_tri_unpacker_if.sv
// Beat stream into the unpacker and parallel triangle descriptor out of it.
// Each bundle has a master/slave modport pair.
interface rc_axis_if;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tready;
    logic        tlast;

    modport master (output tdata, tvalid, tlast, input  tready);
    modport slave  (input  tdata, tvalid, tlast, output tready);
endinterface

interface rc_tri_if #(
    parameter int Z_W = 16
);
    logic           valid;
    logic           ready;
    logic [31:0]    header;
    logic [31:0]    lz0;
    logic [31:0]    lz1;
    logic [31:0]    ld0;
    logic [31:0]    ld1;
    logic [31:0]    ld2;
    logic [31:0]    ld3;
    logic [Z_W-1:0] z0;
    logic [Z_W-1:0] zd0;
    logic [Z_W-1:0] zd1;

    modport master (output valid, header, lz0, lz1, ld0, ld1, ld2, ld3, z0, zd0, zd1,
                    input  ready);
    modport slave  (input  valid, header, lz0, lz1, ld0, ld1, ld2, ld3, z0, zd0, zd1,
                    output ready);
endinterface

// File: rtl/rc_tri_unpacker.sv
// Collects 10-beat triangle packets into an assembly buffer and hands complete
// descriptors to the raster core through a second, output-side register stage.
module rc_tri_unpacker #(
    parameter int Z_W   = 16,
    parameter int CNT_W = 16
) (
    input  logic             aclk,
    input  logic             areset,
    rc_axis_if.slave         s_axis,
    rc_tri_if.master         m_tri,
    output logic             err_short,
    output logic             err_long,
    output logic [CNT_W-1:0] pkt_count,
    output logic [CNT_W-1:0] err_count
);
    typedef enum logic [1:0] {S_COLLECT, S_HOLD, S_DRAIN} state_t;

    state_t         state, state_n;
    logic [3:0]     cnt, cnt_n;
    logic           rdy_en;
    logic           beat_fire, o_free;
    logic           a_we, load_beat, load_a, short_n, long_n;
    logic [31:0]    a_hdr, a_lz0, a_lz1, a_ld0, a_ld1, a_ld2, a_ld3;
    logic [Z_W-1:0] a_z0, a_zd0, a_zd1;

    // rdy_en keeps tready low until the first clock after reset release.
    assign s_axis.tready = rdy_en && (state != S_HOLD);
    assign beat_fire     = s_axis.tvalid && s_axis.tready;
    assign o_free        = !m_tri.valid || m_tri.ready;

    always_comb begin
        // NOTE: every signal gets a default first, so no path can leave one unassigned and infer a latch.
        state_n   = state;
        cnt_n     = cnt;
        a_we      = 1'b0;
        load_beat = 1'b0;
        load_a    = 1'b0;
        short_n   = 1'b0;
        long_n    = 1'b0;
        unique case (state)
            S_COLLECT: begin
                if (beat_fire) begin
                    a_we = 1'b1;
                    if (cnt == 4'd9) begin
                        cnt_n = 4'd0;
                        if (!s_axis.tlast) begin
                            long_n  = 1'b1;
                            state_n = S_DRAIN;
                        end else if (o_free) begin
                            load_beat = 1'b1;
                        end else begin
                            state_n = S_HOLD;
                        end
                    end else if (s_axis.tlast) begin
                        short_n = 1'b1;
                        cnt_n   = 4'd0;
                    end else begin
                        cnt_n = cnt + 4'd1;
                    end
                end
            end
            S_HOLD: begin
                if (o_free) begin
                    load_a  = 1'b1;
                    state_n = S_COLLECT;
                end
            end
            S_DRAIN: begin
                if (beat_fire && s_axis.tlast) state_n = S_COLLECT;
            end
            default: state_n = S_COLLECT;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state     <= S_COLLECT;
            cnt       <= 4'd0;
            rdy_en    <= 1'b0;
            err_short <= 1'b0;
            err_long  <= 1'b0;
            err_count <= '0;
        end else begin
            // NOTE: clocked state uses <= so every register samples pre-edge values regardless of statement order.
            state     <= state_n;
            cnt       <= cnt_n;
            rdy_en    <= 1'b1;
            err_short <= short_n;
            err_long  <= long_n;
            if (short_n || long_n) err_count <= err_count + CNT_W'(1);
        end
    end

    // NOTE: the assembly buffer has no reset; every field is rewritten before it can reach the output stage.
    always_ff @(posedge aclk) begin
        if (a_we) begin
            case (cnt)
                4'd0:    a_hdr <= s_axis.tdata;
                4'd1:    a_lz0 <= s_axis.tdata;
                4'd2:    a_lz1 <= s_axis.tdata;
                4'd3:    a_ld0 <= s_axis.tdata;
                4'd4:    a_ld1 <= s_axis.tdata;
                4'd5:    a_ld2 <= s_axis.tdata;
                4'd6:    a_ld3 <= s_axis.tdata;
                4'd7:    a_z0  <= s_axis.tdata[Z_W-1:0];
                4'd8:    a_zd0 <= s_axis.tdata[Z_W-1:0];
                4'd9:    a_zd1 <= s_axis.tdata[Z_W-1:0];
                default: ;
            endcase
        end
    end

    // Output stage; the direct path lets the final beat bypass the assembly buffer.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            m_tri.valid  <= 1'b0;
            m_tri.header <= '0;
            m_tri.lz0    <= '0;
            m_tri.lz1    <= '0;
            m_tri.ld0    <= '0;
            m_tri.ld1    <= '0;
            m_tri.ld2    <= '0;
            m_tri.ld3    <= '0;
            m_tri.z0     <= '0;
            m_tri.zd0    <= '0;
            m_tri.zd1    <= '0;
            pkt_count    <= '0;
        end else begin
            if (load_beat || load_a) begin
                m_tri.valid  <= 1'b1;
                m_tri.header <= a_hdr;
                m_tri.lz0    <= a_lz0;
                m_tri.lz1    <= a_lz1;
                m_tri.ld0    <= a_ld0;
                m_tri.ld1    <= a_ld1;
                m_tri.ld2    <= a_ld2;
                m_tri.ld3    <= a_ld3;
                m_tri.z0     <= a_z0;
                m_tri.zd0    <= a_zd0;
                m_tri.zd1    <= load_beat ? s_axis.tdata[Z_W-1:0] : a_zd1;
            end else if (m_tri.ready) begin
                m_tri.valid <= 1'b0;
            end
            if (m_tri.valid && m_tri.ready) pkt_count <= pkt_count + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_rc_tri_unpacker.sv
// Directed bench for rc_tri_unpacker: a packet-level model predicts delivered
// descriptors and error counts; literal checks pin the model on key scenarios.
module tb_rc_tri_unpacker;
    localparam int Z_W   = 16;
    localparam int CNT_W = 16;

    typedef struct packed {
        logic [31:0]    hdr;
        logic [31:0]    lz0;
        logic [31:0]    lz1;
        logic [31:0]    ld0;
        logic [31:0]    ld1;
        logic [31:0]    ld2;
        logic [31:0]    ld3;
        logic [Z_W-1:0] z0;
        logic [Z_W-1:0] zd0;
        logic [Z_W-1:0] zd1;
    } desc_t;

    logic             aclk = 1'b0;
    logic             areset = 1'b1;
    logic             err_short, err_long;
    logic [CNT_W-1:0] pkt_count, err_count;

    rc_axis_if          s_axis ();
    rc_tri_if #(.Z_W(Z_W)) m_tri ();

    rc_tri_unpacker #(.Z_W(Z_W), .CNT_W(CNT_W)) dut (
        .aclk      (aclk),
        .areset    (areset),
        .s_axis    (s_axis),
        .m_tri     (m_tri),
        .err_short (err_short),
        .err_long  (err_long),
        .pkt_count (pkt_count),
        .err_count (err_count)
    );

    always #5 aclk = ~aclk;

    desc_t       exp_q[$];
    int          n_xfer, exp_err, n_total, n_bad, n_long, cyc;
    logic [31:0] pb[12];
    desc_t       prev_desc, cur;
    bit          prev_hold;

    task automatic check(input string name, input logic [287:0] act, input logic [287:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic desc_t dut_desc();
        desc_t d;
        d.hdr = m_tri.header; d.lz0 = m_tri.lz0; d.lz1 = m_tri.lz1;
        d.ld0 = m_tri.ld0; d.ld1 = m_tri.ld1; d.ld2 = m_tri.ld2; d.ld3 = m_tri.ld3;
        d.z0 = m_tri.z0; d.zd0 = m_tri.zd0; d.zd1 = m_tri.zd1;
        return d;
    endfunction

    // Descriptor implied by the packet currently in pb: raw words, z fields truncated.
    function automatic desc_t pkt_desc();
        desc_t d;
        d.hdr = pb[0]; d.lz0 = pb[1]; d.lz1 = pb[2];
        d.ld0 = pb[3]; d.ld1 = pb[4]; d.ld2 = pb[5]; d.ld3 = pb[6];
        d.z0 = pb[7][Z_W-1:0]; d.zd0 = pb[8][Z_W-1:0]; d.zd1 = pb[9][Z_W-1:0];
        return d;
    endfunction

    task automatic fill_pkt(input logic [31:0] hdr);
        pb[0] = hdr;
        for (int i = 1; i < 12; i++) pb[i] = 32'((hdr << 4) ^ (32'h0101_0101 * i));
    endtask

    // Sends n beats from pb (tlast on the final one if with_last) and updates the model.
    task automatic send_pkt(input int n, input bit with_last);
        for (int i = 0; i < n; i++) begin
            int guard = 0;
            s_axis.tdata  = pb[i];
            s_axis.tvalid = 1'b1;
            s_axis.tlast  = with_last && (i == n - 1);
            while (!s_axis.tready && guard < 200) begin
                @(negedge aclk);
                guard++;
            end
            if (guard >= 200) begin
                n_total++; n_bad++;
                $display("FAIL tready_timeout: beat %0d never accepted", i);
                s_axis.tvalid = 1'b0;
                return;
            end
            @(posedge aclk);
            if (i == 9) begin
                if (with_last && n == 10) exp_q.push_back(pkt_desc());
                else exp_err++;
            end
            if (with_last && i == n - 1 && n < 10) exp_err++;
            @(negedge aclk);
        end
        s_axis.tvalid = 1'b0;
        s_axis.tlast  = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge aclk);
        #1 areset = 1'b1;
        @(negedge aclk);
        areset = 1'b0;
        @(negedge aclk);
    endtask

    always @(posedge aclk) cyc++;
    always @(negedge aclk) if (err_long) n_long++;

    // Per-cycle comparison against the packet-level model, sampled mid low phase.
    always begin
        @(negedge aclk);
        #2;
        if (areset) begin
            exp_q.delete();
            n_xfer    = 0;
            exp_err   = 0;
            prev_hold = 1'b0;
        end else begin
            cur = dut_desc();
            check("pkt_count", pkt_count, n_xfer[CNT_W-1:0]);
            check("err_count", err_count, exp_err[CNT_W-1:0]);
            check("err_exclusive", err_short & err_long, 1'b0);
            if (prev_hold) begin
                check("hold_valid", m_tri.valid, 1'b1);
                check("hold_data", cur, prev_desc);
            end
            if (m_tri.valid && m_tri.ready) begin
                if (exp_q.size() == 0) begin
                    n_total++; n_bad++;
                    $display("FAIL unexpected_desc: got header %0h expected none", cur.hdr);
                end else begin
                    check("desc", cur, exp_q[0]);
                    void'(exp_q.pop_front());
                    n_xfer++;
                end
            end
            prev_hold = m_tri.valid && !m_tri.ready;
            prev_desc = cur;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, nl0;
        s_axis.tdata = '0; s_axis.tvalid = 1'b0; s_axis.tlast = 1'b0;
        m_tri.ready = 1'b0;

        // Reset state
        #12;
        check("rst_tready", s_axis.tready, 1'b0);
        check("rst_valid", m_tri.valid, 1'b0);
        check("rst_header", m_tri.header, 32'h0);
        check("rst_counts", {pkt_count, err_count, err_short, err_long}, '0);
        @(negedge aclk);
        areset = 1'b0;
        @(posedge aclk);
        #1 check("tready_after_release", s_axis.tready, 1'b1);
        @(negedge aclk);
        m_tri.ready = 1'b1;

        // 1: single packet, one-cycle latency
        pb[0] = 32'h001103C0; pb[1] = 32'h10000000; pb[2] = 32'h20000000;
        pb[3] = 32'h00100000; pb[4] = 32'h00200000; pb[5] = 32'h00150000;
        pb[6] = 32'h00250000; pb[7] = 32'h00001000; pb[8] = 32'h00000010; pb[9] = 32'h00000020;
        send_pkt(10, 1'b1);
        check("t1_valid", m_tri.valid, 1'b1);
        check("t1_header", m_tri.header, 32'h001103C0);
        check("t1_lz1", m_tri.lz1, 32'h20000000);
        check("t1_ld2", m_tri.ld2, 32'h00150000);
        check("t1_z", {m_tri.z0, m_tri.zd0, m_tri.zd1}, 48'h1000_0010_0020);
        @(negedge aclk);
        check("t1_pkt_count", pkt_count, 16'd1);
        check("t1_valid_drop", m_tri.valid, 1'b0);

        // 2: back-pressure and HOLD
        do_reset();
        m_tri.ready = 1'b0;
        fill_pkt(32'h001103C0);
        send_pkt(10, 1'b1);
        fill_pkt(32'h002103C0);
        pb[8] = 32'h0000FFF0;
        send_pkt(10, 1'b1);
        check("t2_hold_tready", s_axis.tready, 1'b0);
        check("t2_hold_header", m_tri.header, 32'h001103C0);
        m_tri.ready = 1'b1;
        @(negedge aclk);
        m_tri.ready = 1'b0;
        check("t2_new_header", m_tri.header, 32'h002103C0);
        check("t2_new_zd0", m_tri.zd0, 16'hFFF0);
        check("t2_tready_back", s_axis.tready, 1'b1);
        check("t2_pkt_count1", pkt_count, 16'd1);
        repeat (2) @(negedge aclk);
        m_tri.ready = 1'b1;
        @(negedge aclk);
        check("t2_pkt_count2", pkt_count, 16'd2);

        // 3: short packet dropped, next packet clean
        fill_pkt(32'h00000BAD);
        send_pkt(5, 1'b1);
        check("t3_err_short", err_short, 1'b1);
        check("t3_err_count", err_count, 16'd1);
        @(negedge aclk);
        check("t3_err_short_pulse", err_short, 1'b0);
        check("t3_no_valid", m_tri.valid, 1'b0);
        fill_pkt(32'h000A007F);
        send_pkt(10, 1'b1);
        check("t3_header", m_tri.header, 32'h000A007F);
        @(negedge aclk);

        // 4: long packet drained, next packet intact
        nl0 = n_long;
        fill_pkt(32'h0C0FFEE0);
        send_pkt(12, 1'b1);
        check("t4_err_long_pulses", n_long - nl0, 1);
        check("t4_err_count", err_count, 16'd2);
        check("t4_no_valid", m_tri.valid, 1'b0);
        fill_pkt(32'h00DD0001);
        send_pkt(10, 1'b1);
        check("t4_header", m_tri.header, 32'h00DD0001);

        // 5: continuous stream, no tready gaps
        c0 = cyc;
        for (int p = 0; p < 3; p++) begin
            fill_pkt(32'h00500000 + 32'(p));
            send_pkt(10, 1'b1);
        end
        check("t5_stream_cycles", cyc - c0, 30);
        repeat (2) @(negedge aclk);
        check("t5_pkt_count", pkt_count, 16'd7);

        // 6: reset mid-packet
        fill_pkt(32'h00666666);
        send_pkt(6, 1'b0);
        #1 areset = 1'b1;
        #1;
        check("t6_async_tready", s_axis.tready, 1'b0);
        check("t6_async_outputs", {m_tri.valid, pkt_count, err_count}, '0);
        @(negedge aclk);
        areset = 1'b0;
        fill_pkt(32'h00ABCDEF);
        send_pkt(10, 1'b1);
        check("t6_header", m_tri.header, 32'h00ABCDEF);
        @(negedge aclk);
        check("t6_pkt_count", pkt_count, 16'd1);
        check("t6_err_count", err_count, 16'd0);

        repeat (5) @(negedge aclk);
        check("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
